// File: rtl/jtag_pkg.sv
// Shared types and TMS walk patterns for the JTAG master.
// Patterns are stored LSB-first: bit 0 is driven in the first TCK period.
package jtag_pkg;

   typedef enum logic [1:0] {
      CMD_TAP_RESET = 2'd0,
      CMD_IR_SCAN   = 2'd1,
      CMD_DR_SCAN   = 2'd2,
      CMD_RSVD      = 2'd3
   } cmd_type_e;

   typedef enum logic [2:0] {
      IDLE,
      SEQ_PRE,
      SHIFT,
      SEQ_POST,
      RESP
   } state_e;

   localparam logic [7:0] TMS_RESET  = 8'b0001_1111;
   localparam logic [2:0] RESET_LEN  = 3'd6;
   localparam logic [7:0] TMS_IR_PRE = 8'b0000_0011;
   localparam logic [2:0] IR_PRE_LEN = 3'd4;
   localparam logic [7:0] TMS_DR_PRE = 8'b0000_0001;
   localparam logic [2:0] DR_PRE_LEN = 3'd3;
   localparam logic [7:0] TMS_POST   = 8'b0000_0001;
   localparam logic [2:0] POST_LEN   = 3'd2;

   function automatic logic [7:0] pre_tms(input cmd_type_e t);
      case (t)
         CMD_TAP_RESET: pre_tms = TMS_RESET;
         CMD_IR_SCAN:   pre_tms = TMS_IR_PRE;
         default:       pre_tms = TMS_DR_PRE;
      endcase
   endfunction

   function automatic logic [2:0] pre_len(input cmd_type_e t);
      case (t)
         CMD_TAP_RESET: pre_len = RESET_LEN;
         CMD_IR_SCAN:   pre_len = IR_PRE_LEN;
         default:       pre_len = DR_PRE_LEN;
      endcase
   endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: square wave of 2*CLK_DIV clk cycles, low half first, parked low when disabled.
// rise_pulse/fall_pulse flag the clk cycle whose closing edge moves TCK.
module jtag_tck_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   output logic TCK,
   output logic rise_pulse,
   output logic fall_pulse
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_q;
   logic          tc;

   assign tc         = (div_q == '0);
   assign rise_pulse = enable && tc && !TCK;
   assign fall_pulse = enable && tc && TCK;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= DIV_LOAD;
         TCK   <= 1'b0;
      end else if (!enable) begin
         div_q <= DIV_LOAD;
         TCK   <= 1'b0;
      end else if (tc) begin
         div_q <= DIV_LOAD;
         TCK   <= ~TCK;
      end else begin
         div_q <= div_q - 1'b1;
      end
   end

endmodule

// File: rtl/jtag_master.sv
// Command-driven JTAG master: TAP reset, IR scan and DR scan with TDO capture.
//
//   state    | meaning
//   IDLE     | cmd_ready high, TCK parked low
//   SEQ_PRE  | TMS walk from Run-Test/Idle into Shift-IR/DR (or 5x1,0 for TAP reset)
//   SHIFT    | cmd_len bits on TDI, TDO captured, TMS=1 on the last bit
//   SEQ_POST | TMS 1,0 through Update back to Run-Test/Idle
//   RESP     | response held until rsp_ready
module jtag_master
   import jtag_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int MAX_LEN = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [1:0]                   cmd_type,
   input  logic [$clog2(MAX_LEN+1)-1:0] cmd_len,
   input  logic [MAX_LEN-1:0]           cmd_data,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [MAX_LEN-1:0]           rsp_data,
   output logic                         rsp_err,
   output logic                         TCK,
   output logic                         TMS,
   output logic                         TDI,
   input  logic                         TDO
);

   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int CW = (LW > 3) ? LW : 3;
   localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);

   state_e              state_q, state_nxt;
   cmd_type_e           typ_q, typ_nxt, new_typ;
   logic [LW-1:0]       len_q, len_nxt;
   logic [MAX_LEN-1:0]  data_q, data_nxt;
   logic [MAX_LEN-1:0]  cap_q, cap_nxt;
   logic [7:0]          pat_q, pat_nxt, pre_bits;
   logic [CW-1:0]       cnt_q, cnt_nxt;
   logic                tms_q, tms_nxt;
   logic                tdi_q, tdi_nxt;
   logic                err_q, err_nxt;
   logic                illegal;
   logic                tck_en, rise_pulse, fall_pulse;

   assign tck_en = (state_q == SEQ_PRE) || (state_q == SHIFT) || (state_q == SEQ_POST);

   jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (tck_en),
      .TCK        (TCK),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse)
   );

   // Length limits only matter for scans; a TAP reset ignores cmd_len.
   assign new_typ = cmd_type_e'(cmd_type);
   assign illegal = (new_typ == CMD_RSVD) ||
                    ((new_typ != CMD_TAP_RESET) && ((cmd_len == '0) || (cmd_len > MAX_LEN_L)));

   always_comb begin
      state_nxt = state_q;
      typ_nxt   = typ_q;
      len_nxt   = len_q;
      data_nxt  = data_q;
      cap_nxt   = cap_q;
      pat_nxt   = pat_q;
      cnt_nxt   = cnt_q;
      tms_nxt   = tms_q;
      tdi_nxt   = tdi_q;
      err_nxt   = err_q;
      pre_bits  = pre_tms(new_typ);

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               typ_nxt  = new_typ;
               len_nxt  = cmd_len;
               data_nxt = cmd_data;
               cap_nxt  = '0;
               if (illegal) begin
                  err_nxt   = 1'b1;
                  state_nxt = RESP;
               end else begin
                  err_nxt   = 1'b0;
                  state_nxt = SEQ_PRE;
                  pat_nxt   = pre_bits;
                  cnt_nxt   = CW'(pre_len(new_typ)) - CW'(1);
                  tms_nxt   = pre_bits[0];
                  tdi_nxt   = 1'b0;
               end
            end
         end

         SEQ_PRE: begin
            if (fall_pulse) begin
               if (cnt_q == '0) begin
                  if (typ_q == CMD_TAP_RESET) begin
                     state_nxt = RESP;
                  end else begin
                     state_nxt = SHIFT;
                     cnt_nxt   = CW'(len_q) - CW'(1);
                     tms_nxt   = (len_q == LW'(1));
                     tdi_nxt   = data_q[0];
                  end
               end else begin
                  cnt_nxt = cnt_q - CW'(1);
                  pat_nxt = pat_q >> 1;
                  tms_nxt = pat_nxt[0];
               end
            end
         end

         SHIFT: begin
            // First captured bit ends up at the bottom after right-alignment.
            if (rise_pulse)
               cap_nxt = MAX_LEN'({TDO, cap_q} >> 1);
            if (fall_pulse) begin
               if (cnt_q == '0) begin
                  state_nxt = SEQ_POST;
                  pat_nxt   = TMS_POST;
                  cnt_nxt   = CW'(POST_LEN) - CW'(1);
                  tms_nxt   = TMS_POST[0];
                  tdi_nxt   = 1'b0;
               end else begin
                  cnt_nxt  = cnt_q - CW'(1);
                  data_nxt = data_q >> 1;
                  tdi_nxt  = data_nxt[0];
                  tms_nxt  = (cnt_q == CW'(1));
               end
            end
         end

         SEQ_POST: begin
            if (fall_pulse) begin
               if (cnt_q == '0) begin
                  state_nxt = RESP;
               end else begin
                  cnt_nxt = cnt_q - CW'(1);
                  pat_nxt = pat_q >> 1;
                  tms_nxt = pat_nxt[0];
               end
            end
         end

         RESP: begin
            if (rsp_ready)
               state_nxt = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         typ_q   <= CMD_TAP_RESET;
         len_q   <= '0;
         data_q  <= '0;
         cap_q   <= '0;
         pat_q   <= '0;
         cnt_q   <= '0;
         tms_q   <= 1'b1;
         tdi_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_nxt;
         typ_q   <= typ_nxt;
         len_q   <= len_nxt;
         data_q  <= data_nxt;
         cap_q   <= cap_nxt;
         pat_q   <= pat_nxt;
         cnt_q   <= cnt_nxt;
         tms_q   <= tms_nxt;
         tdi_q   <= tdi_nxt;
         err_q   <= err_nxt;
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_err   = (state_q == RESP) && err_q;
   assign rsp_data  = ((state_q == RESP) && !err_q) ? (cap_q >> (MAX_LEN_L - len_q)) : '0;
   assign TMS       = tms_q;
   assign TDI       = tdi_q;

endmodule
